// File: rtl/forwarding_hazard_controller.sv
// Forwarding and load-use hazard controller for the EX-stage operand muxes.
// Tracks the EX, MEM and WB instructions' destination state in shadow slots,
// registers the ALU operand select codes one cycle ahead of EX, and issues a
// one-cycle stall on load-use with a saturating stall counter.
module forwarding_hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [CNT_W-1:0]      stall_count
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EXM  = 2'b01;
    localparam logic [1:0] SEL_MWB  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [1:0]       fwd_a_sel_q, fwd_a_sel_d;
    logic [1:0]       fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard;
    logic             rs_hit;
    logic             rt_hit;

    // Select code for one source operand: $0 always reads as constant zero,
    // then the youngest producer wins (EX slot before MEM slot).
    function automatic logic [1:0] select_code(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  uses,
        input slot_t                 ex_s,
        input slot_t                 mem_s
    );
        logic [1:0] code;
        code = SEL_RF;
        if (src == '0) begin
            code = SEL_ZERO;
        end else if (!uses) begin
            code = SEL_RF;
        end else if (ex_s.valid && ex_s.reg_write && (ex_s.rd == src)) begin
            code = SEL_EXM;
        end else if (mem_s.valid && mem_s.reg_write && (mem_s.rd == src)) begin
            code = SEL_MWB;
        end
        return code;
    endfunction

    // Load-use detection against the load currently in EX; flush overrides.
    always_comb begin
        rs_hit = id_uses_rs && (id_rs == ex_q.rd);
        rt_hit = id_uses_rt && (id_rt == ex_q.rd);
        hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && (rs_hit || rt_hit);
        stall  = id_valid && hazard && !flush;
    end

    // Slot advance, EX load or bubble, select computation and stall counting.
    always_comb begin
        wb_d          = mem_q;
        mem_d         = ex_q;
        ex_d          = '0;
        fwd_a_sel_d   = SEL_RF;
        fwd_b_sel_d   = SEL_RF;
        stall_count_d = stall_count_q;

        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            fwd_a_sel_d    = select_code(id_rs, id_uses_rs, ex_q, mem_q);
            fwd_b_sel_d    = select_code(id_rt, id_uses_rt, ex_q, mem_q);
        end

        if (stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset clearing all in-flight state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            fwd_a_sel_q   <= SEL_RF;
            fwd_b_sel_q   <= SEL_RF;
            stall_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            fwd_a_sel_q   <= fwd_a_sel_d;
            fwd_b_sel_q   <= fwd_b_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fwd_a_sel   = fwd_a_sel_q;
    assign fwd_b_sel   = fwd_b_sel_q;
    assign stall_count = stall_count_q;

endmodule

// File: doc/forwarding_hazard_controller.md
Name: forwarding_hazard_controller

Overview:
- Sequencing controller for the EX-stage operand forwarding muxes of the 5-stage MIPS pipeline.
- Tracks destination-register state of the instructions in EX, MEM and WB in internal shadow slots.
- Produces registered 2-bit select codes for the ALU A and B operand 4:1 muxes.
- Detects load-use hazards, issues a one-cycle stall, and counts stalls for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-address width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_ADDR_W  source A register of the ID instruction.
- id_rt  in  REG_ADDR_W  source B register of the ID instruction.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes id_rd.
- id_mem_read  in  1  ID instruction is a load.
- flush  in  1  discard the ID instruction (taken branch/jump).
- stall  out  1  freeze PC and IF/ID this cycle; combinational.
- fwd_a_sel  out  2  operand A mux select, valid during EX; registered.
- fwd_b_sel  out  2  operand B mux select, valid during EX; registered.
- stall_count  out  CNT_W  number of stall cycles issued, saturating.

Behaviour:
- Select encoding:
  - 00 = register-file operand.
  - 01 = EX/MEM result.
  - 10 = MEM/WB result.
  - 11 = constant zero (source is $0).
- Internal slots EX, MEM and WB each hold {valid, rd, reg_write, mem_read}.
- Reset (rst_n=0 at a clk edge):
  - All slots are invalid.
  - fwd_a_sel = fwd_b_sel = 00.
  - stall_count = 0.
  - stall therefore evaluates to 0.
- Hazard: asserted when EX.valid & EX.mem_read & EX.rd != 0, and either:
  - id_uses_rs & id_rs == EX.rd, or
  - id_uses_rt & id_rt == EX.rd.
- Output stall = id_valid & hazard & ~flush.
- Every clock edge, slots advance: MEM→WB and EX→MEM.
- EX slot load rule:
  - If stall or flush or ~id_valid: EX loads a bubble (valid=0), and both selects register 00.
  - Otherwise: EX loads {1, id_rd, id_reg_write, id_mem_read}, and the selects register the computed codes below.
- Select computation, per operand with source s (rs or rt), priority high to low:
  1. s == 0 → 11. This applies even if an older instruction targets $0.
  2. EX.valid & EX.reg_write & EX.rd == s → 01.
  3. MEM.valid & MEM.reg_write & MEM.rd == s → 10.
  4. Otherwise → 00.
- An operand whose id_uses_x = 0 selects 00, unless its source is 0, in which case it selects 11.
- WB-slot matches need no forwarding. The register file is write-before-read, so WB is tracked only so the slot-state contract stays complete.
- Forward-select latency: one cycle. A select is computed in ID and presented throughout the instruction's EX cycle.
- Stall is exactly one cycle per load-use. The bubble enters EX, so next cycle the load sits in MEM and the dependent operand selects 10.
- Simultaneous flush and hazard: flush wins. stall = 0, a bubble enters EX, and the counter does not increment.
- stall_count increments by 1 on each edge where stall = 1. It holds at 2^CNT_W−1.
- Reset asserted mid-operation clears all in-flight state on that edge; no partial forwarding survives.

Test Plan:
- Reset → hold rst_n=0 for 2 cycles with random ID inputs → stall=0, both selects 00, stall_count=0.
- EX/MEM forward → issue add $3 (reg_write) then add using rs=$3 back-to-back → during the second instruction's EX, fwd_a_sel=01, stall never asserted.
- MEM/WB forward and priority:
  - Issue writer $4, one independent instruction, then a reader of rt=$4 → fwd_b_sel=10.
  - Repeat with writers to $4 in both EX and MEM slots → fwd_b_sel=01.
- $0 handling → writer targets $0, next instruction reads rs=$0 → fwd_a_sel=11 and no stall, even when the writer is a load.
- Load-use:
  - Issue lw $5 then add reading $5 → stall=1 for exactly one cycle, and stall_count goes 0→1.
  - After the stall, the add's EX cycle shows fwd_a_sel=10.
- Flush/saturation:
  - Assert flush during a load-use hazard → stall=0, the counter is unchanged, and the next EX selects are 00.
  - With CNT_W=2, issue 5 load-use stalls → stall_count is 3.
